// File: rtl/cmd_pkg.sv
// Shared constants, function codes and parser state encoding for the
// switch-board command frame parser.
package cmd_pkg;

    localparam int UART_FIFO_COUNTER_W = 5;

    localparam logic [7:0] HDR0    = 8'hEB;
    localparam logic [7:0] HDR1    = 8'h90;
    localparam logic [7:0] TAIL0   = 8'h09;
    localparam logic [7:0] TAIL1   = 8'hD7;
    localparam logic [7:0] TGT_SWB = 8'hAB;

    localparam logic [3:0] FN_HOST   = 4'd1;
    localparam logic [3:0] FN_RST    = 4'd2;
    localparam logic [3:0] FN_RSTALL = 4'd3;
    localparam logic [3:0] FN_PWRON  = 4'd4;
    localparam logic [3:0] FN_PWROFF = 4'd5;

    // State names carry an S_ prefix so they do not clash with the tail byte constants.
    typedef enum logic [2:0] {
        S_HUNT0, S_HUNT1, S_BODY, S_TAIL0, S_TAIL1, S_EXEC
    } parse_state_e;

endpackage

// File: rtl/cmd_frame_parser_if.sv
// UART FIFO side of the command parser: RX FIFO pop port and TX FIFO echo port.
interface cmd_frame_parser_if #(
    parameter int CNT_W = cmd_pkg::UART_FIFO_COUNTER_W
);
    logic [7:0]       rdr;
    logic [CNT_W-1:0] rf_counter;
    logic             rf_pop;
    logic [7:0]       tdr;
    logic             tf_push;

    modport master (input rdr, rf_counter, output rf_pop, tdr, tf_push);
    modport slave  (output rdr, rf_counter, input rf_pop, tdr, tf_push);
endinterface

// File: rtl/cmd_reset_pulse.sv
// Fixed-length reset pulse for one CPU; a trigger while active reloads the length.
module cmd_reset_pulse #(
    parameter int unsigned RESET_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic cpu_reset
);
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt_q <= '0;
        else if (trig)           cnt_q <= RESET_CYCLES;
        else if (cnt_q != '0)    cnt_q <= cnt_q - 32'd1;
    end

    assign cpu_reset = (cnt_q != '0);
endmodule

// File: rtl/cmd_frame_parser.sv
// EB 90 framed command parser driving host select, CPU resets and power enables.
// Define CMD_ECHO_EN to echo every popped byte to the TX FIFO.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int          NUM_CPU      = 2,
    parameter int          FRAME_LEN    = 8,
    parameter int unsigned RESET_CYCLES = 1000,
    parameter int          IDLE_TIMEOUT = 640,
    localparam int         HS_W         = $clog2(NUM_CPU)
) (
    input  logic                clk,
    input  logic                rst_n,
    cmd_frame_parser_if.master  uart,
    input  logic [HS_W-1:0]     host_cur,
    output logic [HS_W-1:0]     host_sel,
    output logic                force_swi,
    output logic [NUM_CPU-1:0]  cpu_reset,
    output logic [NUM_CPU-1:0]  power_on,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);
    localparam int              PCNT_W    = 4;
    localparam int              IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [PCNT_W-1:0] PLAST   = PCNT_W'(FRAME_LEN - 5);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [4:0]      NCPU      = 5'(NUM_CPU);

    parse_state_e         state_q, state_d;
    logic                 pop, pop_q, active, timeout, err_abort;
    logic [7:0]           chk_q, p0_q, p1_q;
    logic [PCNT_W-1:0]    pcnt_q;
    logic                 tail_ok_q;
    logic [IDLE_W-1:0]    idle_q;
    logic [3:0]           fn, n;
    logic [HS_W-1:0]      idx;
    logic                 fn_ok, n_ok, ok_c, err_c, swi_c;
    logic [NUM_CPU-1:0]   rst_trig, pwr_d;
    logic [HS_W-1:0]      host_d;

    // pop_q resets high so nothing is popped while in reset or on the first cycle after.
    assign pop         = (uart.rf_counter != '0) && !pop_q;
    assign uart.rf_pop = pop;
    assign active      = state_q inside {S_HUNT1, S_BODY, S_TAIL0, S_TAIL1};
    assign timeout     = active && !pop && (idle_q == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q     <= 1'b1;
            state_q   <= S_HUNT0;
            idle_q    <= '0;
            chk_q     <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            pcnt_q    <= '0;
            tail_ok_q <= 1'b0;
        end else begin
            pop_q   <= pop;
            state_q <= state_d;
            idle_q  <= (active && !pop) ? idle_q + IDLE_W'(1) : '0;
            if (pop) begin
                case (state_q)
                    S_HUNT1: begin chk_q <= '0; pcnt_q <= '0; end
                    S_BODY: begin
                        chk_q  <= chk_q + uart.rdr;
                        pcnt_q <= pcnt_q + PCNT_W'(1);
                        if (pcnt_q == PCNT_W'(0)) p0_q <= uart.rdr;
                        if (pcnt_q == PCNT_W'(1)) p1_q <= uart.rdr;
                    end
                    S_TAIL0: tail_ok_q <= (uart.rdr == TAIL0);
                    S_TAIL1: tail_ok_q <= tail_ok_q && (uart.rdr == TAIL1);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        err_abort = 1'b0;
        if (timeout) begin
            state_d   = S_HUNT0;
            err_abort = 1'b1;
        end else if (pop) begin
            case (state_q)
                S_HUNT0: if (uart.rdr == HDR0) state_d = S_HUNT1;
                S_HUNT1: begin
                    // A repeated EB is treated as a fresh header start.
                    if (uart.rdr == HDR1) state_d = S_BODY;
                    else if (uart.rdr != HDR0) begin
                        state_d   = S_HUNT0;
                        err_abort = 1'b1;
                    end
                end
                S_BODY:  if (pcnt_q == PLAST) state_d = S_TAIL0;
                S_TAIL0: state_d = S_TAIL1;
                S_TAIL1: state_d = S_EXEC;
                default: ;
            endcase
        end
        if (state_q == S_EXEC) state_d = S_HUNT0;
    end

    assign fn    = p1_q[7:4];
    assign n     = p1_q[3:0];
    assign idx   = n[HS_W-1:0];
    assign fn_ok = (fn >= FN_HOST) && (fn <= FN_PWROFF);
    assign n_ok  = {1'b0, n} < NCPU;

    always_comb begin
        ok_c     = 1'b0;
        err_c    = err_abort;
        swi_c    = 1'b0;
        rst_trig = '0;
        pwr_d    = power_on;
        host_d   = host_sel;
        if (state_q == S_EXEC) begin
            if (chk_q != 8'h00 || !tail_ok_q) err_c = 1'b1;
            else if (p0_q != TGT_SWB)         ok_c  = 1'b1;
            else if (!fn_ok || !n_ok)         err_c = 1'b1;
            else begin
                ok_c = 1'b1;
                case (fn)
                    FN_HOST:   begin host_d = idx; swi_c = 1'b1; end
                    FN_RST:    if (idx != host_cur) rst_trig[idx] = 1'b1;
                    FN_RSTALL: begin rst_trig = '1; host_d = idx; swi_c = 1'b1; end
                    FN_PWRON:  pwr_d[idx] = 1'b1;
                    FN_PWROFF: if (idx != host_cur) pwr_d[idx] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_sel  <= '0;
            force_swi <= 1'b0;
            power_on  <= '1;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            host_sel  <= host_d;
            force_swi <= swi_c;
            power_on  <= pwr_d;
            frame_ok  <= ok_c;
            frame_err <= err_c;
            if (err_c && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CPU; g++) begin : g_rst
        cmd_reset_pulse #(.RESET_CYCLES(RESET_CYCLES)) u_pulse (
            .clk       (clk),
            .rst_n     (rst_n),
            .trig      (rst_trig[g]),
            .cpu_reset (cpu_reset[g])
        );
    end

`ifdef CMD_ECHO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart.tdr     <= '0;
            uart.tf_push <= 1'b0;
        end else begin
            uart.tf_push <= pop;
            if (pop) uart.tdr <= uart.rdr;
        end
    end
`else
    assign uart.tdr     = '0;
    assign uart.tf_push = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: NUM_CPU=4, short reset pulse and idle timeout.
module tb_cmd_frame_parser;
    localparam int NUM_CPU = 4, FRAME_LEN = 8, RESET_CYCLES = 20, IDLE_TIMEOUT = 64;

    localparam logic [63:0] F_HOST3   = 64'hEB90_AB13_4200_09D7;
    localparam logic [63:0] F_BADSUM  = 64'hEB90_AB13_4201_09D7;
    localparam logic [63:0] F_RST2    = 64'hEB90_AB22_3300_09D7;
    localparam logic [63:0] F_HOST1   = 64'hEB90_AB11_4400_09D7;
    localparam logic [63:0] F_HOST2   = 64'hEB90_AB12_4300_09D7;
    localparam logic [63:0] F_NOTSWB  = 64'hEB90_5513_9800_09D7;
    localparam logic [63:0] F_BADTAIL = 64'hEB90_AB13_4200_09D8;
    localparam logic [63:0] F_BADN    = 64'hEB90_AB15_4000_09D7;
    localparam logic [63:0] F_BADFN   = 64'hEB90_AB73_E200_09D7;
    localparam logic [63:0] F_PWROFF1 = 64'hEB90_AB51_0400_09D7;
    localparam logic [63:0] F_PWRON1  = 64'hEB90_AB41_1400_09D7;
    localparam logic [63:0] F_RSTALL2 = 64'hEB90_AB32_2300_09D7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] host_cur, host_sel;
    logic       force_swi, frame_ok, frame_err;
    logic [3:0] cpu_reset, power_on;
    logic [7:0] err_cnt;
    int         checks = 0;
    int         errors = 0;

    cmd_frame_parser_if uart ();

    cmd_frame_parser #(
        .NUM_CPU(NUM_CPU), .FRAME_LEN(FRAME_LEN),
        .RESET_CYCLES(RESET_CYCLES), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart(uart), .host_cur(host_cur),
        .host_sel(host_sel), .force_swi(force_swi), .cpu_reset(cpu_reset),
        .power_on(power_on), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offer one byte at the FIFO head and return #1 after the edge that consumed it.
    task automatic send(input logic [7:0] b);
        int k = 0;
        uart.rdr = b;
        uart.rf_counter = 5'd1;
        @(negedge clk);
        while (uart.rf_pop !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("rf_pop", uart.rf_pop, 1);
        step();
        uart.rf_counter = 5'd0;
`ifdef CMD_ECHO_EN
        check("echo_push", uart.tf_push, 1);
        check("echo_tdr", uart.tdr, b);
`else
        check("echo_push_off", uart.tf_push, 0);
        check("echo_tdr_off", uart.tdr, 0);
`endif
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) send(f[i*8 +: 8]);
    endtask

    initial begin
        int cyc;
        uart.rdr = 8'h00;
        uart.rf_counter = 5'd1;
        host_cur = 2'd0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_rf_pop", uart.rf_pop, 0);
        check("rst_tf_push", uart.tf_push, 0);
        check("rst_tdr", uart.tdr, 0);
        check("rst_force_swi", force_swi, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_host_sel", host_sel, 0);
        check("rst_cpu_reset", cpu_reset, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_power_on", power_on, 4'hF);
        uart.rf_counter = 5'd0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // Host switch to CPU 3
        send_frame(F_HOST3);
        check("host_t1_swi", force_swi, 0);
        step();
        check("host_sel", host_sel, 3);
        check("host_swi", force_swi, 1);
        check("host_ok", frame_ok, 1);
        step();
        check("host_swi_end", force_swi, 0);
        check("host_ok_end", frame_ok, 0);

        // Bad checksum: error only
        send_frame(F_BADSUM);
        step();
        check("badsum_err", frame_err, 1);
        check("badsum_ok", frame_ok, 0);
        check("badsum_cnt", err_cnt, 1);
        check("badsum_host", host_sel, 3);
        check("badsum_swi", force_swi, 0);
        check("badsum_pwr", power_on, 4'hF);
        check("badsum_rst", cpu_reset, 0);

        // Reset CPU 2 for exactly RESET_CYCLES
        send_frame(F_RST2);
        check("rst2_t1", cpu_reset, 0);
        step();
        check("rst2_rise", cpu_reset, 4'b0100);
        check("rst2_ok", frame_ok, 1);
        cyc = 1;
        while (cpu_reset != 4'b0000 && cyc < 200) begin
            step();
            if (cpu_reset == 4'b0100) cyc++;
        end
        check("rst2_len", cyc, RESET_CYCLES);

        // Same frame targeting the current host is ignored
        host_cur = 2'd2;
        send_frame(F_RST2);
        step();
        check("rst_host_ok", frame_ok, 1);
        check("rst_host_none", cpu_reset, 0);

        // Extra EB before the 90 still syncs
        send(8'hEB);
        send_frame(F_HOST1);
        step();
        check("ebeb_host", host_sel, 1);
        check("ebeb_ok", frame_ok, 1);

        // EB 55 aborts in HUNT1
        send(8'hEB);
        send(8'h55);
        check("eb55_err", frame_err, 1);
        check("eb55_cnt", err_cnt, 2);

        // Partial frame then idle gap
        for (int i = 7; i >= 2; i--) send(F_HOST3[i*8 +: 8]);
        cyc = 0;
        while (frame_err !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        check("timeout_gap", cyc, IDLE_TIMEOUT);
        check("timeout_cnt", err_cnt, 3);
        send_frame(F_HOST2);
        step();
        check("after_to_host", host_sel, 2);
        check("after_to_ok", frame_ok, 1);

        // Other target: ok, no action
        send_frame(F_NOTSWB);
        step();
        check("notswb_ok", frame_ok, 1);
        check("notswb_host", host_sel, 2);
        check("notswb_swi", force_swi, 0);

        send_frame(F_BADTAIL);
        step();
        check("badtail_err", frame_err, 1);
        check("badtail_cnt", err_cnt, 4);

        send_frame(F_BADN);
        step();
        check("badn_err", frame_err, 1);
        check("badn_pwr", power_on, 4'hF);
        check("badn_cnt", err_cnt, 5);

        send_frame(F_BADFN);
        step();
        check("badfn_err", frame_err, 1);
        check("badfn_cnt", err_cnt, 6);

        // Power control
        host_cur = 2'd0;
        send_frame(F_PWROFF1);
        check("pwroff_t1", power_on, 4'hF);
        step();
        check("pwroff", power_on, 4'b1101);
        check("pwroff_ok", frame_ok, 1);
        send_frame(F_PWRON1);
        step();
        check("pwron", power_on, 4'hF);
        host_cur = 2'd1;
        send_frame(F_PWROFF1);
        step();
        check("pwroff_host_ok", frame_ok, 1);
        check("pwroff_host", power_on, 4'hF);
        host_cur = 2'd0;
        send_frame(F_PWROFF1);
        step();
        check("pwroff2", power_on, 4'b1101);

        // Reset all, then async reset clears everything
        send_frame(F_RSTALL2);
        step();
        check("rstall_rst", cpu_reset, 4'hF);
        check("rstall_host", host_sel, 2);
        check("rstall_swi", force_swi, 1);
        check("rstall_pwr", power_on, 4'b1101);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("arst_cpu_reset", cpu_reset, 0);
        check("arst_power", power_on, 4'hF);
        check("arst_host", host_sel, 0);
        check("arst_cnt", err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Reset mid-frame discards the partial frame
        for (int i = 7; i >= 4; i--) send(F_HOST3[i*8 +: 8]);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        send_frame(F_HOST3);
        step();
        check("midrst_host", host_sel, 3);
        check("midrst_ok", frame_ok, 1);
        check("midrst_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Parametrised successor to the switch-board command decoder. It pops bytes from the UART RX FIFO and resynchronises on the EB 90 frame header. It validates checksum and tail, then drives host selection, per-CPU reset pulses and per-CPU power enables for `NUM_CPU` processors instead of the fixed A/B pair. It sits between `uart_rx` FIFO and the switch/power logic, optionally echoing every byte to the UART TX FIFO.

## Interface
- `NUM_CPU`, 2: number of managed CPUs, 2..16.
- `FRAME_LEN`, 8: total frame bytes including 2 header and 2 tail bytes, 8..16.
- `RESET_CYCLES`, 1000: reset pulse length in clk cycles, 1..2^32-1.
- `IDLE_TIMEOUT`, 640: inter-byte gap in cycles that aborts a partial frame.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdr`  in  8  RX FIFO head byte.
- `rf_counter`  in  `UART_FIFO_COUNTER_W`  RX FIFO fill level.
- `rf_pop`  out  1  one-cycle pop strobe.
- `tdr`  out  8  byte to TX FIFO.
- `tf_push`  out  1  one-cycle push strobe.
- `host_cur`  in  $clog2(NUM_CPU)  index of CPU currently acting as host.
- `host_sel`  out  $clog2(NUM_CPU)  commanded host index.
- `force_swi`  out  1  one-cycle strobe: apply `host_sel`.
- `cpu_reset`  out  NUM_CPU  active-high reset per CPU.
- `power_on`  out  NUM_CPU  power enable per CPU.
- `frame_ok`, `frame_err`  out  1  one-cycle result strobes.
- `err_cnt`  out  8  saturating bad-frame counter.

## Operation
- Frame: byte0 EB, byte1 90, payload P[0..FRAME_LEN-5], tail 09 D7.
  - P[0] is the target; AB means switch board.
  - P[1] is the opcode: [7:4] function, [3:0] CPU index n.
  - Valid iff sum of all P bytes mod 256 == 0 and both tail bytes match.
- Parser states:
  - HUNT0: wait for EB, then go to HUNT1.
  - HUNT1: 90 goes to BODY. EB stays in HUNT1. Any other byte returns to HUNT0 and raises `frame_err`.
  - BODY: stores P bytes and accumulates an 8-bit checksum.
  - TAIL0, TAIL1: compare tail bytes.
  - EXEC: one cycle, then return to HUNT0.
- Gap of IDLE_TIMEOUT cycles without a pop while in HUNT1/BODY/TAIL goes to HUNT0 with `frame_err`. The timeout does not fire in HUNT0.
- Frame with P[0] != AB is valid but ignored: `frame_ok` pulses with no action.
- Functions (n >= NUM_CPU gives `frame_err`, no action):
  - 1: `host_sel`=n, pulse `force_swi`.
  - 2: reset n, only if n != `host_cur`; otherwise ignored.
  - 3: reset all CPUs, `host_sel`=n, pulse `force_swi`.
  - 4: `power_on[n]`=1.
  - 5: `power_on[n]`=0, only if n != `host_cur`.
  - Other function codes: `frame_err`.
- `err_cnt` increments on each `frame_err` and saturates at FF.
- Reset values:
  - `rf_pop`, `tf_push`, `force_swi`, `frame_ok`, `frame_err` = 0.
  - `tdr` = 0, `host_sel` = 0, `cpu_reset` = 0, `err_cnt` = 0.
  - `power_on` = all ones.
  - Parser state = HUNT0.
- Reset mid-frame discards the partial frame. Active reset pulses clear immediately.

## Timing
- `rf_pop` is asserted when `rf_counter` != 0 and no pop occurred in the previous cycle, giving at most one pop per 2 cycles (FIFO count latency). `rdr` is sampled in the pop cycle T.
- Parser state advances at T+1.
- For the last tail byte popped at T: EXEC at T+1. `frame_ok`/`frame_err`, `force_swi`, `host_sel`, `power_on` and the rising edge of `cpu_reset` all change at T+2.
- `cpu_reset[n]` stays high exactly RESET_CYCLES cycles. A retrigger while high reloads the counter.
- Echo: `tf_push`/`tdr` valid at T+1 for the byte popped at T.

## Configuration
- `CMD_ECHO_EN` defined: every popped byte is echoed to the TX FIFO as above.
- `CMD_ECHO_EN` not defined: `tf_push` and `tdr` are tied to 0, and the echo register is not built.

## Structure
- Package `cmd_pkg`:
  - constants HDR0=EB, HDR1=90, TAIL0=09, TAIL1=D7, TGT_SWB=AB;
  - function codes FN_HOST..FN_PWROFF;
  - parser state enum.
- Sub-module `cmd_reset_pulse`: one down-counter plus output, parametrised by RESET_CYCLES, instantiated NUM_CPU times.

## Test plan
- NUM_CPU=4, frame EB 90 AB 13 42 00 09 D7 (sum AB+13+42 = 100 mod 256 = 00), host_cur=0 -> at T+2 `host_sel`=3, `force_swi` 1 cycle, `frame_ok`.
- Reset CPU 2 (opcode 22) with host_cur=0 -> `cpu_reset`=0100 for exactly RESET_CYCLES. Same frame with host_cur=2 -> no reset, `frame_ok`.
- Checksum off by 1 -> `frame_err`, `err_cnt`=1, all outputs unchanged.
- Stream EB EB 90 followed by a valid body -> frame accepted. Stream EB 55 -> `frame_err`, back to HUNT0.
- Six bytes of a frame, then a gap of IDLE_TIMEOUT cycles -> `frame_err`; a following valid frame is accepted.
- Power off CPU 1 (opcode 51), then `rst_n` pulsed -> `power_on[1]`=0 after the frame, all ones after reset. With `CMD_ECHO_EN` defined, each byte appears on `tdr` with `tf_push`.
